// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and byte type
package i2c_pkg;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef logic [7:0] i2c_byte_t;

endpackage

// File: rtl/i2c_byte_fifo.sv
// rtl/i2c_byte_fifo.sv - synchronous byte FIFO with push/pop/full/empty/count
import i2c_pkg::*;

module i2c_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  i2c_byte_t        push_data,
    input  logic             pop,
    output i2c_byte_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    i2c_byte_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only when it is drained in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Head is masked while empty so the output is defined straight out of reset.
    assign head = empty ? i2c_byte_t'(8'h00) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2c_rx_buffer.sv
// rtl/i2c_rx_buffer.sv - I2C receive byte buffer with ACK/NACK from occupancy; I2C_RX_BUFFER_OVF_CNT_EN adds dropped-byte counter
import i2c_pkg::*;

module i2c_rx_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             rx_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_rdy,
    input  logic             rx_ack_en,
    output logic             rx_ack,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [7:0]       ovf_count
);

    logic rdy_q;
    logic capture;
    logic pop;
    logic accept;
    logic push;
    logic full;
    logic empty;
    logic unused_ack_en;

    assign unused_ack_en = rx_ack_en;

    assign capture   = rdy_q & ~rx_data_rdy;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign accept    = ~full | pop;
    assign push      = capture & accept;

    i2c_byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .head      (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // rdy_q clears on reset so an ack phase straddling reset never looks like a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b0;
            rx_n  <= 1'b1;
        end else begin
            rdy_q <= rx_data_rdy;
            rx_n  <= ~enable;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ack <= I2C_NACK;
        end else if (capture) begin
            rx_ack <= accept ? I2C_ACK : I2C_NACK;
        end else if (rx_data_rdy) begin
            rx_ack <= I2C_NACK;
        end
    end

    // A drop in the same cycle as ovf_clr must not be lost, so the event has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (capture & ~accept) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef I2C_RX_BUFFER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= 8'h00;
        end else if (capture & ~accept) begin
            if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
        end else if (ovf_clr) begin
            ovf_count <= 8'h00;
        end
    end
`else
    assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_rx_buffer.sv
// tb/tb_i2c_rx_buffer.sv - directed self-checking bench for i2c_rx_buffer
module tb_i2c_rx_buffer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       rx_n;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       rx_ack_en;
    logic       rx_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] ovf_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef I2C_RX_BUFFER_OVF_CNT_EN
    localparam logic [7:0] EXP_OVF1 = 8'h01;
    localparam logic [7:0] EXP_SAT  = 8'hFF;
`else
    localparam logic [7:0] EXP_OVF1 = 8'h00;
    localparam logic [7:0] EXP_SAT  = 8'h00;
`endif

    i2c_rx_buffer #(.DEPTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rx_n        (rx_n),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .rx_ack_en   (rx_ack_en),
        .rx_ack      (rx_ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .ovf_count   (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rx_ack_en = rx_data_rdy;

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data     = b;
        rx_data_rdy = 1'b0;
        repeat (hold) @(negedge clk);
        rx_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (rx_n !== 1'b1) $display("FAIL reset_rx_n got %b exp 1", rx_n); else pass_cnt++;
        total_cnt++; if (rx_ack !== 1'b1) $display("FAIL reset_rx_ack got %b exp 1", rx_ack); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else pass_cnt++;
        total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else pass_cnt++;
        total_cnt++; if (ovf_count !== 8'h00) $display("FAIL reset_ovf_count got %h exp 00", ovf_count); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_n !== 1'b0) $display("FAIL post_reset_rx_n got %b exp 0", rx_n); else pass_cnt++;
    endtask

    task automatic test_single_byte;
        rx_data     = 8'hA5;
        rx_data_rdy = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b0) $display("FAIL single_ack got %b exp 0", rx_ack); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 8'hA5) $display("FAIL single_data got %h exp a5", out_data); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL single_count got %0d exp 1", count); else pass_cnt++;
        repeat (19) @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b0) $display("FAIL single_ack_hold got %b exp 0", rx_ack); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL single_no_recapture got %0d exp 1", count); else pass_cnt++;
        rx_data_rdy = 1'b1;
        @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b1) $display("FAIL single_ack_release got %b exp 1", rx_ack); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++; if (count !== 5'd0) $display("FAIL single_pop_count got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_pop_valid got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_fill_overflow;
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rx_data     = 8'(i);
            rx_data_rdy = 1'b0;
            @(negedge clk);
            total_cnt++; if (rx_ack !== 1'b0) $display("FAIL fill_ack byte %0d got %b exp 0", i, rx_ack); else pass_cnt++;
            @(negedge clk);
            rx_data_rdy = 1'b1;
            repeat (2) @(negedge clk);
        end
        total_cnt++; if (count !== 5'd16) $display("FAIL fill_count got %0d exp 16", count); else pass_cnt++;
        rx_data     = 8'h11;
        rx_data_rdy = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b1) $display("FAIL ovf_nack got %b exp 1", rx_ack); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else pass_cnt++;
        total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count_stays got %0d exp 16", count); else pass_cnt++;
        total_cnt++; if (ovf_count !== EXP_OVF1) $display("FAIL ovf_counter got %h exp %h", ovf_count, EXP_OVF1); else pass_cnt++;
        rx_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_with_pop;
        logic [7:0] exp_b;
        rx_data     = 8'h22;
        rx_data_rdy = 1'b0;
        out_ready   = 1'b1;
        total_cnt++; if (out_data !== 8'h01) $display("FAIL fullpop_first got %h exp 01", out_data); else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++; if (rx_ack !== 1'b0) $display("FAIL fullpop_ack got %b exp 0", rx_ack); else pass_cnt++;
        total_cnt++; if (count !== 5'd16) $display("FAIL fullpop_count got %0d exp 16", count); else pass_cnt++;
        rx_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            exp_b = (k < 15) ? 8'(k + 2) : 8'h22;
            total_cnt++; if (out_data !== exp_b) $display("FAIL drain_order idx %0d got %h exp %h", k, out_data, exp_b); else pass_cnt++;
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total_cnt++; if (count !== 5'd0) $display("FAIL drain_count got %0d exp 0", count); else pass_cnt++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clr_flag got %b exp 0", overflow); else pass_cnt++;
        total_cnt++; if (ovf_count !== 8'h00) $display("FAIL ovf_clr_counter got %h exp 00", ovf_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid_ack;
        rx_data     = 8'h5A;
        rx_data_rdy = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b1) $display("FAIL midack_ack got %b exp 1", rx_ack); else pass_cnt++;
        total_cnt++; if (count !== 5'd0) $display("FAIL midack_count got %0d exp 0", count); else pass_cnt++;
        rx_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rx_data     = 8'h3C;
        rx_data_rdy = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b0) $display("FAIL next_ack got %b exp 0", rx_ack); else pass_cnt++;
        total_cnt++; if (out_data !== 8'h3C) $display("FAIL next_data got %h exp 3c", out_data); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL next_count got %0d exp 1", count); else pass_cnt++;
        rx_data_rdy = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_enable;
        enable = 1'b0;
        total_cnt++; if (rx_n !== 1'b0) $display("FAIL en_rx_n_before got %b exp 0", rx_n); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rx_n !== 1'b1) $display("FAIL en_rx_n_after got %b exp 1", rx_n); else pass_cnt++;
        rx_data     = 8'h77;
        rx_data_rdy = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_ack !== 1'b0) $display("FAIL en_off_ack got %b exp 0", rx_ack); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL en_off_count got %0d exp 1", count); else pass_cnt++;
        rx_data_rdy = 1'b1;
        enable      = 1'b1;
        @(negedge clk);
        total_cnt++; if (rx_n !== 1'b0) $display("FAIL en_rx_n_back got %b exp 0", rx_n); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_ovf_clr_collision;
        for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 2);
        rx_data     = 8'h99;
        rx_data_rdy = 1'b0;
        ovf_clr     = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL clr_collide_flag got %b exp 1", overflow); else pass_cnt++;
        total_cnt++; if (ovf_count !== EXP_OVF1) $display("FAIL clr_collide_counter got %h exp %h", ovf_count, EXP_OVF1); else pass_cnt++;
        total_cnt++; if (rx_ack !== 1'b1) $display("FAIL clr_collide_nack got %b exp 1", rx_ack); else pass_cnt++;
        rx_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 260; i++) send_byte(8'hEE, 1);
        total_cnt++; if (ovf_count !== EXP_SAT) $display("FAIL ovf_saturate got %h exp %h", ovf_count, EXP_SAT); else pass_cnt++;
        total_cnt++; if (count !== 5'd16) $display("FAIL sat_count got %0d exp 16", count); else pass_cnt++;
        total_cnt++; if (out_data !== 8'h80) $display("FAIL sat_head got %h exp 80", out_data); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_stream;
        logic [7:0] q[$];
        logic       exp_ack;
        logic       do_pop;
        logic       do_cap;
        logic       acc;
        int         phase;
        int         pushed;
        int         popped;
        int         budget;
        exp_ack = 1'b1;
        pushed  = 0;
        popped  = 0;
        for (int c = 0; c < 160; c++) begin
            phase = c % 4;
            total_cnt++; if (count !== 5'(q.size())) $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, q.size()); else pass_cnt++;
            total_cnt++; if (count > 5'd16) $display("FAIL rnd_count_max cyc %0d got %0d exp <=16", c, count); else pass_cnt++;
            total_cnt++; if (out_valid !== (q.size() != 0)) $display("FAIL rnd_valid cyc %0d got %b exp %b", c, out_valid, q.size() != 0); else pass_cnt++;
            if (q.size() != 0) begin
                total_cnt++; if (out_data !== q[0]) $display("FAIL rnd_data cyc %0d got %h exp %h", c, out_data, q[0]); else pass_cnt++;
            end
            if (phase == 3) begin
                total_cnt++; if (rx_ack !== exp_ack) $display("FAIL rnd_ack cyc %0d got %b exp %b", c, rx_ack, exp_ack); else pass_cnt++;
            end
            out_ready   = 1'($urandom_range(0, 1));
            rx_data     = 8'h40 + 8'(c / 4);
            rx_data_rdy = (phase < 2);
            do_pop = (q.size() != 0) && out_ready;
            do_cap = (phase == 2);
            acc    = (q.size() < 16) || do_pop;
            if (do_cap) exp_ack = acc ? 1'b0 : 1'b1;
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_cap && acc) begin
                q.push_back(rx_data);
                pushed++;
            end
            @(negedge clk);
        end
        rx_data_rdy = 1'b1;
        out_ready   = 1'b1;
        budget      = 0;
        while (q.size() != 0 && budget < 40) begin
            total_cnt++; if (out_data !== q[0]) $display("FAIL rnd_drain got %h exp %h", out_data, q[0]); else pass_cnt++;
            void'(q.pop_front());
            popped++;
            budget++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rnd_empty got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (pushed !== 40) $display("FAIL rnd_pushed got %0d exp 40", pushed); else pass_cnt++;
        total_cnt++; if (popped !== pushed) $display("FAIL rnd_popped got %0d exp %0d", popped, pushed); else pass_cnt++;
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b1;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_full_with_pop();
        test_reset_mid_ack();
        test_enable();
        test_ovf_clr_collision();
        test_random_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
